cb_slave_responder: RTL and testbench
=====================================

Name: cb_slave_responder

Overview:
- Behavioural/synthesizable slave endpoint for one crossbar slave port. It is the responder side of the req/addr/cmd/wdata -> ack/rdata/resp handshake.
- Receives requests routed by the crossbar and acknowledges them after a programmable number of wait states.
- Executes reads and writes against a small internal register memory.
- Returns read data and resp one cycle after ack.
- Four instances attach to slave ports 1-4 in the crossbar test/emulation top.

Parameters:
- ADDR_W, 11, width of slave_addr
- DATA_W, 11, width of slave_wdata and slave_rdata
- MEM_DEPTH, 16, number of memory words; power of 2, indexed by slave_addr[$clog2(MEM_DEPTH)-1:0]
- MAX_WAIT_W, 4, width of wait_cfg

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- wait_cfg  in  MAX_WAIT_W  wait states inserted between request sampling and ack; 0..15
- slave_req  in  1  request from crossbar; held by crossbar until ack
- slave_addr  in  ADDR_W  request address
- slave_cmd  in  1  0 = read, 1 = write
- slave_wdata  in  DATA_W  write data, valid with slave_req
- slave_ack  out  1  one-cycle pulse: request accepted
- slave_rdata  out  DATA_W  read data, valid when slave_resp=1 for a read; 0 otherwise
- slave_resp  out  1  one-cycle pulse, one cycle after slave_ack, for both read and write
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, slave_ack=0, slave_resp=0, slave_rdata=0, busy=0, wait counter=0, all memory words=0. Reset mid-transaction drops it; there is no ack and no resp afterwards, and any write that has not yet been acked is not committed.
- All outputs are registered.
- FSM states: IDLE, WAIT, ACK, RESP.
- IDLE:
  - If slave_req=1 at a rising edge, latch addr, cmd, wdata and wait_cfg.
  - Go to WAIT if wait_cfg>0 (counter=wait_cfg), else to ACK.
- WAIT:
  - Counter decrements each cycle; go to ACK when counter reaches 1.
  - If slave_req=0 in WAIT (protocol violation), abort to IDLE with no ack and no write.
  - Changes to addr/cmd/wdata during WAIT are ignored; the latched values are used.
- ACK:
  - slave_ack=1 for exactly this cycle.
  - Write: mem[idx] <= latched wdata at the end of this cycle.
  - Read: slave_rdata is loaded from mem[idx] at the end of this cycle.
  - Next state is RESP.
- RESP:
  - slave_resp=1 for exactly this cycle. slave_rdata holds read data for a read, 0 for a write.
  - If slave_req=1 at this edge, it is a new request: sample it exactly as in IDLE (back-to-back). Otherwise go to IDLE.
  - slave_rdata returns to 0 in the cycle after RESP.
- Latency for a request first sampled at edge T:
  - slave_ack high in cycle T+1+wait_cfg.
  - slave_resp high in cycle T+2+wait_cfg.
  - Minimum back-to-back throughput is one transaction per 2 cycles (wait_cfg=0).
- Address: upper bits above $clog2(MEM_DEPTH) are ignored. Addresses alias, e.g. 0x010 aliases 0x000 with depth 16.
- Read-after-write to the same index in consecutive transactions returns the new data, because the write commits in ACK before the next sample.
- wait_cfg changes only affect transactions sampled afterwards.

Decomposition:
- Shared package cb_pkg holds:
  - localparams CB_ADDR_W=11 and CB_DATA_W=11
  - CMD_READ=1'b0 and CMD_WRITE=1'b1
  - typedef enum logic [1:0] {IDLE, WAIT, ACK, RESP} cb_slv_state_t
- One natural sub-module: cb_slave_mem, a register array with one write port and one registered read port, async reset to 0, instantiated once.
- FSM and wait counter live in the top of the block.

Test Plan:
1. reset=1 for 3 cycles mid-stream (req=1, wait_cfg=5, state WAIT) -> all outputs 0 immediately; after release, with req=0, ack/resp stay 0 and a read of addr 0x003 returns 0x000.
2. wait_cfg=0: write addr=0x005 wdata=0x2AB, then read addr=0x005 -> ack one cycle after each sample, resp the following cycle, read rdata=0x2AB on the resp cycle, 0 otherwise.
3. wait_cfg=3: read sampled at edge T -> ack exactly in cycle T+4, resp in T+5, busy high T+1..T+5.
4. Back-to-back with req held high across RESP: write 0x001=0x111, write 0x002=0x222, read 0x001 -> acks spaced 2 cycles apart, final rdata=0x111.
5. Aliasing: write addr=0x013 wdata=0x7FF, read addr=0x003 -> rdata=0x7FF.
6. wait_cfg=4, req deasserted 2 cycles after sampling -> no ack, no resp, memory unchanged, busy low next cycle; a following request completes normally.

Source files
------------

// File: rtl/cb_pkg.sv
// Shared crossbar definitions: default bus widths, command encoding and the
// slave responder state type.
package cb_pkg;
   localparam int CB_ADDR_W = 11;
   localparam int CB_DATA_W = 11;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic [1:0] {IDLE, WAIT, ACK, RESP} cb_slv_state_t;
endpackage

// File: rtl/cb_slave_mem.sv
// Register array behind a slave port: one write port, one registered read port.
// The read register is zero whenever no read is issued in the previous cycle.
module cb_slave_mem #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 11,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdata <= '0;
      else       rdata <= re ? mem[raddr] : '0;
   end
endmodule

// File: rtl/cb_slave_responder.sv
// Crossbar slave endpoint: samples a request, inserts wait_cfg wait states,
// pulses ack, then pulses resp with read data one cycle later.
module cb_slave_responder
   import cb_pkg::*;
#(
   parameter int ADDR_W     = CB_ADDR_W,
   parameter int DATA_W     = CB_DATA_W,
   parameter int MEM_DEPTH  = 16,
   parameter int MAX_WAIT_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [MAX_WAIT_W-1:0] wait_cfg,
   input  logic                  slave_req,
   input  logic [ADDR_W-1:0]     slave_addr,
   input  logic                  slave_cmd,
   input  logic [DATA_W-1:0]     slave_wdata,
   output logic                  slave_ack,
   output logic [DATA_W-1:0]     slave_rdata,
   output logic                  slave_resp,
   output logic                  busy
);
   localparam int IDX_W = $clog2(MEM_DEPTH);

   cb_slv_state_t         state;
   logic [MAX_WAIT_W-1:0] cnt;
   logic [IDX_W-1:0]      lat_idx;
   logic                  lat_cmd;
   logic [DATA_W-1:0]     lat_wdata;

   // Upper address bits alias onto the memory index.
   generate
      if (ADDR_W > IDX_W) begin : g_alias
         logic unused_addr_hi;
         assign unused_addr_hi = &{1'b0, slave_addr[ADDR_W-1:IDX_W]};
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_idx    <= '0;
         lat_cmd    <= CMD_READ;
         lat_wdata  <= '0;
         slave_ack  <= 1'b0;
         slave_resp <= 1'b0;
         busy       <= 1'b0;
      end else begin
         slave_ack  <= 1'b0;
         slave_resp <= 1'b0;
         case (state)
            // RESP accepts a new request exactly like IDLE for back-to-back use.
            IDLE, RESP: begin
               if (slave_req) begin
                  lat_idx   <= slave_addr[IDX_W-1:0];
                  lat_cmd   <= slave_cmd;
                  lat_wdata <= slave_wdata;
                  busy      <= 1'b1;
                  if (wait_cfg != '0) begin
                     state <= WAIT;
                     cnt   <= wait_cfg;
                  end else begin
                     state     <= ACK;
                     slave_ack <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            WAIT: begin
               if (!slave_req) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == MAX_WAIT_W'(1)) begin
                  state     <= ACK;
                  cnt       <= '0;
                  slave_ack <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ACK: begin
               state      <= RESP;
               slave_resp <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   logic mem_we, mem_re;
   assign mem_we = (state == ACK) && (lat_cmd == CMD_WRITE);
   assign mem_re = (state == ACK) && (lat_cmd == CMD_READ);

   cb_slave_mem #(
      .DEPTH  (MEM_DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .waddr (lat_idx),
      .wdata (lat_wdata),
      .re    (mem_re),
      .raddr (lat_idx),
      .rdata (slave_rdata)
   );
endmodule

// File: tb/tb_cb_slave_responder.sv
// Directed bench for cb_slave_responder: latency, back-to-back, aliasing,
// abort and mid-transaction reset.
module tb_cb_slave_responder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  wait_cfg = '0;
   logic        slave_req = 1'b0;
   logic [10:0] slave_addr = '0;
   logic        slave_cmd = 1'b0;
   logic [10:0] slave_wdata = '0;
   logic        slave_ack;
   logic [10:0] slave_rdata;
   logic        slave_resp;
   logic        busy;

   int n_chk = 0;
   int n_fail = 0;

   cb_slave_responder dut (
      .clk         (clk),
      .reset       (reset),
      .wait_cfg    (wait_cfg),
      .slave_req   (slave_req),
      .slave_addr  (slave_addr),
      .slave_cmd   (slave_cmd),
      .slave_wdata (slave_wdata),
      .slave_ack   (slave_ack),
      .slave_rdata (slave_rdata),
      .slave_resp  (slave_resp),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one transaction from IDLE and reports what it observed.
   task automatic run_txn(input logic cmd, input logic [10:0] addr, input logic [10:0] wdata,
                          output int ack_lat, output logic resp_ok, output logic [10:0] rd_ack,
                          output logic [10:0] rd_resp, output logic [10:0] rd_after,
                          output logic [31:0] bmask);
      int k;
      slave_req = 1'b1; slave_cmd = cmd; slave_addr = addr; slave_wdata = wdata;
      ack_lat = -1; bmask = '0; resp_ok = 1'b0; rd_ack = '0; rd_resp = '0; rd_after = '0;
      tick();
      k = 1;
      while (k <= 40) begin
         bmask[k-1] = busy;
         if (slave_ack) begin
            ack_lat = k;
            rd_ack = slave_rdata;
            break;
         end
         tick();
         k++;
      end
      slave_req = 1'b0;
      if (ack_lat < 0) return;
      tick(); k++;
      bmask[k-1] = busy;
      resp_ok = slave_resp && !slave_ack;
      rd_resp = slave_rdata;
      tick(); k++;
      bmask[k-1] = busy;
      rd_after = slave_rdata;
      if (slave_resp) resp_ok = 1'b0;
   endtask

   task automatic test_reset();
      int lat; logic rok; logic [10:0] ra, rr, rf; logic [31:0] bm;
      int seen;
      reset = 1'b1;
      repeat (3) tick();
      n_chk++;
      if ({slave_ack, slave_resp, busy, slave_rdata} !== 14'h0) begin
         n_fail++;
         $display("FAIL reset_state: ack=%b resp=%b busy=%b rdata=%h, required all 0",
                  slave_ack, slave_resp, busy, slave_rdata);
      end
      reset = 1'b0;
      tick();
      wait_cfg = 4'd0;
      run_txn(1'b1, 11'h003, 11'h155, lat, rok, ra, rr, rf, bm);
      n_chk++;
      if (lat !== 1) begin n_fail++; $display("FAIL prewrite_ack: lat=%0d, required 1", lat); end
      // Start a write stuck in WAIT, then reset in the middle of it.
      wait_cfg = 4'd5;
      slave_req = 1'b1; slave_cmd = 1'b1; slave_addr = 11'h003; slave_wdata = 11'h3FF;
      repeat (3) tick();
      n_chk++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_wait: busy=%b, required 1", busy); end
      reset = 1'b1;
      #1;
      n_chk++;
      if ({slave_ack, slave_resp, busy, slave_rdata} !== 14'h0) begin
         n_fail++;
         $display("FAIL reset_async: ack=%b resp=%b busy=%b rdata=%h, required all 0",
                  slave_ack, slave_resp, busy, slave_rdata);
      end
      repeat (3) @(posedge clk);
      #1;
      slave_req = 1'b0;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (slave_ack || slave_resp || busy) seen++;
      end
      n_chk++;
      if (seen !== 0) begin n_fail++; $display("FAIL post_reset_quiet: active cycles=%0d, required 0", seen); end
      wait_cfg = 4'd0;
      run_txn(1'b0, 11'h003, 11'h000, lat, rok, ra, rr, rf, bm);
      n_chk++;
      if (lat !== 1 || rok !== 1'b1 || rr !== 11'h000) begin
         n_fail++;
         $display("FAIL post_reset_read: lat=%0d resp=%b rdata=%h, required 1 1 000", lat, rok, rr);
      end
   endtask

   task automatic test_wait0();
      int lat; logic rok; logic [10:0] ra, rr, rf; logic [31:0] bm;
      wait_cfg = 4'd0;
      run_txn(1'b1, 11'h005, 11'h2AB, lat, rok, ra, rr, rf, bm);
      n_chk++;
      if (lat !== 1 || rok !== 1'b1 || rr !== 11'h000 || rf !== 11'h000) begin
         n_fail++;
         $display("FAIL w0_write: lat=%0d resp=%b rdata_resp=%h rdata_after=%h, required 1 1 000 000",
                  lat, rok, rr, rf);
      end
      run_txn(1'b0, 11'h005, 11'h000, lat, rok, ra, rr, rf, bm);
      n_chk++;
      if (lat !== 1 || rok !== 1'b1) begin
         n_fail++; $display("FAIL w0_read_timing: lat=%0d resp=%b, required 1 1", lat, rok);
      end
      n_chk++;
      if (ra !== 11'h000 || rr !== 11'h2AB || rf !== 11'h000) begin
         n_fail++;
         $display("FAIL w0_read_data: ack=%h resp=%h after=%h, required 000 2ab 000", ra, rr, rf);
      end
      n_chk++;
      if (bm !== 32'h3) begin n_fail++; $display("FAIL w0_busy: mask=%h, required 00000003", bm); end
   endtask

   task automatic test_wait3();
      int lat; logic rok; logic [10:0] ra, rr, rf; logic [31:0] bm;
      wait_cfg = 4'd3;
      run_txn(1'b0, 11'h005, 11'h000, lat, rok, ra, rr, rf, bm);
      n_chk++;
      if (lat !== 4 || rok !== 1'b1) begin
         n_fail++; $display("FAIL w3_latency: lat=%0d resp=%b, required 4 1", lat, rok);
      end
      n_chk++;
      if (rr !== 11'h2AB) begin n_fail++; $display("FAIL w3_rdata: rdata=%h, required 2ab", rr); end
      n_chk++;
      if (bm !== 32'h1F) begin n_fail++; $display("FAIL w3_busy: mask=%h, required 0000001f", bm); end
      wait_cfg = 4'd0;
   endtask

   task automatic test_back_to_back();
      logic [7:0]  amask, rmask;
      logic [10:0] rd [1:8];
      int nacks;
      int lat; logic rok; logic [10:0] ra, rr, rf; logic [31:0] bm;
      wait_cfg = 4'd0;
      amask = '0; rmask = '0; nacks = 0;
      slave_req = 1'b1; slave_cmd = 1'b1; slave_addr = 11'h001; slave_wdata = 11'h111;
      for (int c = 1; c <= 8; c++) begin
         tick();
         amask[c-1] = slave_ack;
         rmask[c-1] = slave_resp;
         rd[c] = slave_rdata;
         if (slave_ack) begin
            nacks++;
            if (nacks == 1) begin slave_addr = 11'h002; slave_wdata = 11'h222; end
            else if (nacks == 2) begin slave_cmd = 1'b0; slave_addr = 11'h001; slave_wdata = 11'h000; end
            else slave_req = 1'b0;
         end
      end
      slave_req = 1'b0;
      n_chk++;
      if (amask !== 8'h15) begin n_fail++; $display("FAIL b2b_ack: mask=%h, required 15", amask); end
      n_chk++;
      if (rmask !== 8'h2A) begin n_fail++; $display("FAIL b2b_resp: mask=%h, required 2a", rmask); end
      n_chk++;
      if (rd[2] !== 11'h000 || rd[4] !== 11'h000 || rd[6] !== 11'h111 || rd[7] !== 11'h000) begin
         n_fail++;
         $display("FAIL b2b_rdata: c2=%h c4=%h c6=%h c7=%h, required 000 000 111 000",
                  rd[2], rd[4], rd[6], rd[7]);
      end
      run_txn(1'b0, 11'h002, 11'h000, lat, rok, ra, rr, rf, bm);
      n_chk++;
      if (lat !== 1 || rr !== 11'h222) begin
         n_fail++; $display("FAIL b2b_second_write: lat=%0d rdata=%h, required 1 222", lat, rr);
      end
   endtask

   task automatic test_alias();
      int lat; logic rok; logic [10:0] ra, rr, rf; logic [31:0] bm;
      wait_cfg = 4'd0;
      run_txn(1'b1, 11'h013, 11'h7FF, lat, rok, ra, rr, rf, bm);
      run_txn(1'b0, 11'h003, 11'h000, lat, rok, ra, rr, rf, bm);
      n_chk++;
      if (lat !== 1 || rr !== 11'h7FF) begin
         n_fail++; $display("FAIL alias_read: lat=%0d rdata=%h, required 1 7ff", lat, rr);
      end
   endtask

   task automatic test_abort();
      int lat; logic rok; logic [10:0] ra, rr, rf; logic [31:0] bm;
      int seen;
      wait_cfg = 4'd0;
      run_txn(1'b1, 11'h007, 11'h123, lat, rok, ra, rr, rf, bm);
      wait_cfg = 4'd4;
      slave_req = 1'b1; slave_cmd = 1'b1; slave_addr = 11'h007; slave_wdata = 11'h0AA;
      tick();
      n_chk++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_wait: busy=%b, required 1", busy); end
      tick();
      slave_req = 1'b0;
      slave_wdata = 11'h555;
      tick();
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_low: busy=%b, required 0", busy); end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (slave_ack || slave_resp) seen++;
         tick();
      end
      n_chk++;
      if (seen !== 0) begin n_fail++; $display("FAIL abort_no_ack: ack/resp cycles=%0d, required 0", seen); end
      run_txn(1'b0, 11'h007, 11'h000, lat, rok, ra, rr, rf, bm);
      n_chk++;
      if (lat !== 5 || rok !== 1'b1 || rr !== 11'h123) begin
         n_fail++;
         $display("FAIL abort_followup: lat=%0d resp=%b rdata=%h, required 5 1 123", lat, rok, rr);
      end
      wait_cfg = 4'd0;
   endtask

   initial begin
      test_reset();
      test_wait0();
      test_wait3();
      test_back_to_back();
      test_alias();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
